spi_slave_param: RTL and testbench

Parametrised SPI slave front-end for the single-port RAM path. It samples MOSI on the system clock while SS_n is low and assembles (DATA_WIDTH+2)-bit command frames: 2-bit opcode followed by DATA_WIDTH payload bits. Each complete frame is presented to the RAM controller on rx_data/rx_valid. For read-data frames, it accepts the RAM's tx_data/tx_valid reply and serialises it MSB-first on MISO. It sits between the SPI pins and the RAM wrapper.

---
 rtl/spi_slave_pkg.sv | 26 ++
 rtl/spi_tx_shifter.sv | 71 +++++++
 rtl/spi_slave_param.sv | 124 ++++++++++++
 tb/tb_spi_slave_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - state encoding, direction and opcode constants for spi_slave_param
package spi_slave_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHK_CMD   = 3'd1;
  localparam logic [2:0] ST_WRITE     = 3'd2;
  localparam logic [2:0] ST_READ_ADD  = 3'd3;
  localparam logic [2:0] ST_READ_DATA = 3'd4;
  localparam logic [2:0] ST_TX_SEND   = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ  = 1'b1;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  function automatic int frame_width(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - read-reply latch and MSB-first MISO shifter
module spi_tx_shifter
  import spi_slave_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic MISO_IDLE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  miso,
  output logic                  last
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] latch_q;
  logic                  latch_full;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  shifting;

  // last is high during the cycle in which the LSB is on MISO
  assign last = shifting && (bit_cnt == CNT_W'(DATA_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q    <= '0;
      latch_full <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      shifting   <= 1'b0;
      miso       <= MISO_IDLE;
    end else if (clear) begin
      latch_full <= 1'b0;
      bit_cnt    <= '0;
      shifting   <= 1'b0;
      miso       <= MISO_IDLE;
    end else begin
      if (tx_valid && !latch_full) begin
        latch_q    <= tx_data;
        latch_full <= 1'b1;
      end
      if (enable) begin
        if (!shifting) begin
          if (latch_full) begin
            miso       <= latch_q[DATA_WIDTH-1];
            shreg      <= latch_q << 1;
            latch_full <= 1'b0;
            shifting   <= 1'b1;
            bit_cnt    <= CNT_W'(1);
          end else begin
            miso <= MISO_IDLE;
          end
        end else if (last) begin
          miso     <= MISO_IDLE;
          shifting <= 1'b0;
          bit_cnt  <= '0;
        end else begin
          miso    <= shreg[DATA_WIDTH-1];
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - SPI slave front-end for the RAM path; frame_err via SPI_SLAVE_FRAME_ERR_EN
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic MISO_IDLE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int W     = frame_width(DATA_WIDTH);
  localparam int CNT_W = $clog2(W + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-2:0]     shreg;
  logic             rd_addr_done;
  logic             tx_last;
  logic             rx_state;
  logic             last_bit;

  assign rx_state = (state == ST_WRITE) || (state == ST_READ_ADD) || (state == ST_READ_DATA);
  assign last_bit = (cnt == CNT_W'(W - 1));

  spi_tx_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .MISO_IDLE (MISO_IDLE)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state == ST_IDLE) || SS_n),
    .enable  ((state == ST_TX_SEND) && !SS_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .miso    (MISO),
    .last    (tx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_done <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n && (state != ST_IDLE)) begin
        // deselect drops any partial frame; a reply whose LSB was already out counts as finished
        state <= ST_IDLE;
        cnt   <= '0;
        if ((state == ST_TX_SEND) && tx_last) rd_addr_done <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (!SS_n) state <= ST_CHK_CMD;
          end
          ST_CHK_CMD: begin
            cnt <= '0;
            if (MOSI == DIR_WRITE)  state <= ST_WRITE;
            else if (!rd_addr_done) state <= ST_READ_ADD;
            else                    state <= ST_READ_DATA;
          end
          ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            shreg <= {shreg[W-3:0], MOSI};
            if (last_bit) begin
              rx_data  <= {shreg, MOSI};
              rx_valid <= 1'b1;
              cnt      <= '0;
              if (state == ST_READ_DATA) begin
                state <= ST_TX_SEND;
              end else begin
                state <= ST_DONE;
                if (state == ST_READ_ADD) rd_addr_done <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_TX_SEND: begin
            if (tx_last) begin
              rd_addr_done <= 1'b0;
              state        <= ST_DONE;
            end
          end
          ST_DONE: begin
            cnt <= '0;
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  // the READ_DATA term cannot fire by construction and serves as an assertion hook
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= (SS_n && (rx_state || ((state == ST_TX_SEND) && !tx_last)))
                || ((state == ST_READ_DATA) && (cnt == '0) && !rd_addr_done);
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - table-driven bench for spi_slave_param (DATA_WIDTH=8)
module tb_spi_slave_param;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
`endif

  spi_slave_param #(
    .DATA_WIDTH(8),
    .MISO_IDLE (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       mosi;
    logic       txv;
    logic [7:0] txd;
    logic       miso;
    logic       rxv;
    logic [9:0] rxd;
    logic       ferr;
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] cur_rxd;
  int         checks;
  int         errors;
  int         vec_no;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic push(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd,
                      input logic miso, input logic rxv, input logic ferr);
    vec_t v;
    v.ss = ss; v.mosi = mosi; v.txv = txv; v.txd = txd;
    v.miso = miso; v.rxv = rxv; v.rxd = cur_rxd; v.ferr = ferr;
    tbl.push_back(v);
  endtask

  // select, direction bit, then all 10 frame bits MSB first
  task automatic frame(input logic dir, input logic [9:0] bits, input int txv_at, input logic [7:0] txd);
    push(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(1'b0, dir, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) begin
      if (i == 0) cur_rxd = bits;
      push(1'b0, bits[i], (i == txv_at), txd, 1'b0, (i == 0), 1'b0);
    end
  endtask

  task automatic tx_shift(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) push(1'b0, 1'b0, 1'b0, 8'h00, d[i], 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic deselect();
    push(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      SS_n     = tbl[i].ss;
      MOSI     = tbl[i].mosi;
      tx_valid = tbl[i].txv;
      tx_data  = tbl[i].txd;
      @(posedge clk);
      #1;
      chk("miso", vec_no, 32'(MISO), 32'(tbl[i].miso));
      chk("rx_valid", vec_no, 32'(rx_valid), 32'(tbl[i].rxv));
      chk("rx_data", vec_no, 32'(rx_data), 32'(tbl[i].rxd));
`ifdef SPI_SLAVE_FRAME_ERR_EN
      chk("frame_err", vec_no, 32'(frame_err), 32'(tbl[i].ferr));
`endif
      vec_no++;
    end
    tbl.delete();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    vec_no   = 0;
    cur_rxd  = 10'h000;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_miso", -1, 32'(MISO), 32'h0);
    chk("reset_rx_valid", -1, 32'(rx_valid), 32'h0);
    chk("reset_rx_data", -1, 32'(rx_data), 32'h0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("reset_frame_err", -1, 32'(frame_err), 32'h0);
`endif
    rst_n = 1'b1;

    // write address frame, DONE ignores MOSI
    frame(1'b0, 10'b00_1010_0101, -1, 8'h00);
    push(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    deselect();
    // read address, then read data with reply arriving in TX_SEND
    frame(1'b1, 10'b10_0000_0011, -1, 8'h00);
    deselect();
    frame(1'b1, 10'b11_0000_0000, -1, 8'h00);
    push(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    tx_shift(8'hC3);
    deselect();
    // rd_addr_done cleared: this goes to READ_ADD, strobe must not reach MISO
    frame(1'b1, 10'h2AA, 4, 8'hFF);
    push(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    deselect();
    // read data with reply strobed early
    frame(1'b1, 10'h3C5, 5, 8'h5A);
    tx_shift(8'h5A);
    deselect();
    // abort after 5 write bits
    push(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) push(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 10'h15A, -1, 8'h00);
    deselect();
    // back-to-back writes with one deselect cycle
    frame(1'b0, 10'h1C3, -1, 8'h00);
    deselect();
    frame(1'b0, 10'h0F0, -1, 8'h00);
    deselect();
    // read address + read data, stop three bits into the reply
    frame(1'b1, 10'h2F0, -1, 8'h00);
    deselect();
    frame(1'b1, 10'h3F0, 2, 8'hFF);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_table();

    #2;
    tx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("async_rst_miso", -2, 32'(MISO), 32'h0);
    chk("async_rst_rx_valid", -2, 32'(rx_valid), 32'h0);
    chk("async_rst_rx_data", -2, 32'(rx_data), 32'h0);
    SS_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cur_rxd = 10'h000;

    // after reset a read frame must be treated as read address
    deselect();
    frame(1'b1, 10'h201, 3, 8'hFF);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    deselect();
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
